// File: rtl/pipe_barrier.sv
// ============================================================================
// Module      : pipe_barrier
// Description : Elastic valid/ready pipeline barrier with DEPTH register slots,
//               bubble collapse, flush, occupancy and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_barrier #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    input  logic                         flush,
    input  logic                         clr_stats,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [STALL_CNT_W-1:0]       stall_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [STALL_CNT_W-1:0] C_STALL_MAX = '1;

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [OCC_W-1:0]  r_occ;
    logic [STALL_CNT_W-1:0] r_stall;

    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_prev_valid;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [DEPTH-1:0]  w_load;
    logic [DATA_W-1:0] w_prev_data [DEPTH];
    logic [OCC_W-1:0]  w_occ_nxt;
    logic              w_stall_inc;

    // A slot is ready when it or any slot downstream of it is empty, or the
    // sink consumes; this is the unrolled form of the backward ready chain.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!r_valid[j]) begin
                    w_ready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_prev_valid[0] = in_valid;
        w_prev_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_prev_valid[i] = r_valid[i-1];
            w_prev_data[i]  = r_data[i-1];
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_nxt[i] = flush ? 1'b0 : (w_ready[i] ? w_prev_valid[i] : r_valid[i]);
            w_load[i]      = !flush && w_ready[i] && w_prev_valid[i];
            w_occ_nxt      = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            // Empty slots keep stale data; valid=0 hides it.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= w_prev_data[i];
                end
            end
        end
    end

    assign w_stall_inc = r_valid[DEPTH-1] && !out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (clr_stats) begin
            r_stall <= '0;
        end else if (w_stall_inc && (r_stall != C_STALL_MAX)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign in_ready    = w_ready[0] && !flush;
    assign out_valid   = r_valid[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign occupancy   = r_occ;
    assign stall_count = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_pipe_barrier.sv
// ============================================================================
// Module      : tb_pipe_barrier
// Description : Directed self-checking bench for pipe_barrier (DEPTH=3 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_barrier;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;
    logic       clr_stats;

    logic       in_ready3, out_valid3;
    logic [7:0] out_data3;
    logic [1:0] occ3;
    logic [3:0] stall3;

    logic       in_ready2, out_valid2;
    logic [7:0] out_data2;
    logic [1:0] occ2;
    logic [15:0] stall2;

    int n_cmp = 0;
    int n_err = 0;

    pipe_barrier #(.DATA_W(8), .DEPTH(3), .STALL_CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_ready(out_ready), .flush(flush), .clr_stats(clr_stats),
        .occupancy(occ3), .stall_count(stall3)
    );

    pipe_barrier #(.DATA_W(8), .DEPTH(2), .STALL_CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready), .flush(flush), .clr_stats(clr_stats),
        .occupancy(occ2), .stall_count(stall2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        tick();
    endtask

    logic [7:0] sd [3];
    logic [7:0] bp [4];

    initial begin
        sd = '{8'h11, 8'h22, 8'h33};
        bp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check_eq("rst_out_valid", out_valid3, 1'b0);
        check_eq("rst_occ", occ3, 2'd0);
        check_eq("rst_stall", stall3, 4'd0);
        check_eq("rst_in_ready", in_ready3, 1'b1);

        // Asynchronous reset between edges on DEPTH=2
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        check_eq("pre_rst_valid", out_valid2, 1'b1);
        check_eq("pre_rst_data", out_data2, 8'h55);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid2, 1'b0);
        check_eq("arst_out_data", out_data2, 8'h00);
        check_eq("arst_occ", occ2, 2'd0);
        check_eq("arst_stall", stall2, 16'd0);
        check_eq("arst_in_ready", in_ready2, 1'b1);
        tick();
        rst = 1'b1;

        // Streaming on DEPTH=3: latency DEPTH-1 edges after acceptance
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                in_valid = 1'b1;
                in_data  = sd[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < 3) check_eq("stream_in_ready", in_ready3, 1'b1);
            tick();
            if (k >= 2 && k < 5) begin
                check_eq("stream_valid", out_valid3, 1'b1);
                check_eq("stream_data", out_data3, sd[k-2]);
            end else begin
                check_eq("stream_idle", out_valid3, 1'b0);
            end
        end

        // Backpressure and bubble collapse
        out_ready = 1'b0;
        drive(1'b1, 8'hA1);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        check_eq("bp_first_valid", out_valid3, 1'b1);
        check_eq("bp_first_data", out_data3, 8'hA1);
        check_eq("bp_occ1", occ3, 2'd1);
        check_eq("bp_stall0", stall3, 4'd0);
        drive(1'b1, 8'hA2);
        drive(1'b1, 8'hA3);
        check_eq("bp_occ3", occ3, 2'd3);
        check_eq("bp_stall2", stall3, 4'd2);
        in_valid = 1'b1;
        in_data  = 8'hA4;
        #1;
        check_eq("bp_full_in_ready", in_ready3, 1'b0);
        tick();
        tick();
        check_eq("bp_stall4", stall3, 4'd4);
        check_eq("bp_occ_hold", occ3, 2'd3);
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_in_ready", in_ready3, 1'b1);
        check_eq("bp_out0", out_data3, bp[0]);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            check_eq("bp_order_valid", out_valid3, 1'b1);
            check_eq("bp_order_data", out_data3, bp[k]);
            tick();
        end
        check_eq("bp_drained", out_valid3, 1'b0);
        check_eq("bp_stall_final", stall3, 4'd4);

        // Flush of a full DEPTH=3 pipe
        out_ready = 1'b0;
        drive(1'b1, 8'hC1);
        drive(1'b1, 8'hC2);
        drive(1'b1, 8'hC3);
        check_eq("fl_full_occ", occ3, 2'd3);
        check_eq("fl_full_stall", stall3, 4'd4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hBB;
        #1;
        check_eq("fl_in_ready", in_ready3, 1'b0);
        check_eq("fl_out_visible", out_valid3, 1'b1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_occ", occ3, 2'd0);
        check_eq("fl_out_valid", out_valid3, 1'b0);
        check_eq("fl_stall", stall3, 4'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("fl_no_bb", out_valid3, 1'b0);
        end

        // Saturation and clear of the 4-bit stall counter
        out_ready = 1'b0;
        drive(1'b1, 8'hD1);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        check_eq("sat_start", stall3, 4'd4);
        repeat (20) tick();
        check_eq("sat_15", stall3, 4'd15);
        repeat (3) tick();
        check_eq("sat_hold", stall3, 4'd15);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check_eq("clr_zero", stall3, 4'd0);
        tick();
        check_eq("clr_resume", stall3, 4'd1);

        // Mid-operation reset on DEPTH=2
        rst = 1'b0;
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h02);
        drive(1'b1, 8'h03);
        check_eq("mr_pre_valid", out_valid2, 1'b1);
        check_eq("mr_pre_data", out_data2, 8'h02);
        check_eq("mr_pre_occ", occ2, 2'd2);
        in_valid = 1'b1;
        in_data  = 8'h04;
        #2;
        rst = 1'b0;
        #1;
        check_eq("mr_valid", out_valid2, 1'b0);
        check_eq("mr_occ", occ2, 2'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b1, 8'h10);
        check_eq("mr_no_stale", out_valid2, 1'b0);
        drive(1'b1, 8'h20);
        check_eq("mr_first_valid", out_valid2, 1'b1);
        check_eq("mr_first_data", out_data2, 8'h10);
        drive(1'b0, 8'h00);
        check_eq("mr_second_valid", out_valid2, 1'b1);
        check_eq("mr_second_data", out_data2, 8'h20);
        drive(1'b0, 8'h00);
        check_eq("mr_empty", out_valid2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_barrier.md
Name: pipe_barrier

Overview:
- Parametrised elastic pipeline register: the inter-stage barrier that replaces the direct IF→ID→EX→MEM→WB wiring in the pipelined core.
- Carries a DATA_W-bit stage bundle through DEPTH register slots using a valid/ready handshake.
- Supports stall backpressure, bubble collapse, and a flush for branch redirect.
- Reports occupancy and a stall-cycle performance counter.

Parameters:
- DATA_W, 32, width of the stage bundle carried per slot (1..256).
- DEPTH, 2, number of register slots in series (1..8); also the unstalled latency.
- STALL_CNT_W, 16, width of the saturating stall counter (4..32).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream stage presents a bundle.
- in_data  in  DATA_W  upstream bundle.
- in_ready  out  1  barrier accepts the bundle this cycle.
- out_valid  out  1  slot DEPTH-1 holds a valid bundle.
- out_data  out  DATA_W  bundle in slot DEPTH-1.
- out_ready  in  1  downstream stage consumes this cycle.
- flush  in  1  discard every in-flight bundle (branch taken or redirect).
- clr_stats  in  1  synchronous clear of stall_count.
- occupancy  out  $clog2(DEPTH+1)  number of valid slots.
- stall_count  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst=0, all slot valids, all slot data, occupancy and stall_count are 0.
  - Consequently out_valid=0 and out_data=0.
  - in_ready follows the combinational rule below and is therefore 1 during reset.
  - Reset asserted mid-operation drops all contents immediately, without waiting for a clock edge.
- Slots s0..s(DEPTH-1): each holds valid_i and data_i. s0 is fed from in_*; out_* is driven directly from s(DEPTH-1) registers.
- Per-slot ready (combinational chain):
  - ready_(DEPTH-1) = !valid_(DEPTH-1) | out_ready.
  - ready_i = !valid_i | ready_(i+1).
  - in_ready = ready_0 & !flush.
- Transfers:
  - Upstream transfer: in_valid & in_ready.
  - Downstream transfer: out_valid & out_ready & !flush.
- Slot update at each edge, when flush=0:
  - If ready_i=1, slot i loads valid_(i-1) and data_(i-1); slot 0 loads in_valid and in_data.
  - Otherwise slot i holds its contents.
  - Data registers update only when the incoming valid is 1; an empty slot keeps stale data, invisible because valid=0.
- Bubble collapse: an empty slot always accepts its predecessor, even when downstream is stalled. A stalled pipe therefore fills to DEPTH entries with no gaps.
- Latency and throughput:
  - A bundle accepted at edge E appears on out_valid/out_data after edge E+DEPTH-1 (DEPTH=1: visible immediately after the accepting edge).
  - With out_ready held at 1, throughput is 1 bundle per cycle.
- Full/empty:
  - occupancy == DEPTH with out_ready=0 forces in_ready=0.
  - occupancy == 0 forces out_valid=0.
  - A simultaneous push and pop while full is legal and keeps occupancy == DEPTH.
- Flush:
  - Gates in_ready=0 combinationally during the flush cycle. A bundle on in_* in that cycle is neither accepted nor counted.
  - out_valid stays visible, but no downstream transfer occurs.
  - At the next edge all valids become 0 and occupancy becomes 0.
  - Flush has priority over every other update.
- occupancy: registered popcount of the slot valids, updated at the same edge as the slots.
- stall_count:
  - Increments at each edge where out_valid=1, out_ready=0 and flush=0.
  - Saturates at 2^STALL_CNT_W-1 and never wraps.
  - clr_stats=1 sets it to 0 at the edge; clr_stats wins over a simultaneous increment.
- Ordering: bundles leave in exactly the order they were accepted. There is no duplication and no loss except by flush or reset.

Test Plan:
- Reset: DEPTH=2, drive rst=0 asynchronously between edges → out_valid=0, occupancy=0, stall_count=0, in_ready=1, immediately, without waiting for an edge.
- Streaming: DEPTH=3, out_ready=1, push 0x11, 0x22, 0x33 on consecutive edges E, E+1, E+2 → out_data=0x11/0x22/0x33 valid after edges E+2, E+3, E+4; in_ready never drops.
- Backpressure and collapse: DEPTH=3, out_ready=0, push 0xA1, then idle 2 cycles, then push 0xA2, 0xA3, 0xA4 → occupancy reaches 3, in_ready=0 with 0xA4 held upstream, stall_count increments each stalled edge; after releasing out_ready → outputs 0xA1, 0xA2, 0xA3, 0xA4 in order.
- Flush: DEPTH=3 full, assert flush for one cycle while in_valid=1 with in_data=0xBB → in_ready=0 that cycle, occupancy=0 next edge, 0xBB never appears, stall_count unchanged in the flush cycle.
- Saturation and clear: STALL_CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_count=15 and holds; clr_stats=1 with the stall still present → 0 at that edge.
- Mid-operation reset: DEPTH=2, streaming 0x01..0x05, pull rst low after 0x03 is accepted → all valids 0 at once; after release, fresh pushes 0x10, 0x20 emerge with latency 2 and no stale bundles.
